frame_bank_arbiter: RTL and testbench



---
 rtl/frame_bank_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_frame_bank_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_arbiter.sv
// frame_bank_arbiter
// Shares one single-port frame memory between the converter write stream and
// the display read stream. The memory is split into two banks: the converter
// fills one bank while the display reads the other. Banks swap only at a
// display frame start, and only once a finished frame has fully drained to
// memory. Reads always win the memory port. Writes wait in a small FIFO and
// drain in idle read slots (blanking).
//
// Optional build macro: FRAME_BANK_STATS_EN enables the dropped-write counter
// on wr_drop_cnt. Without it the port is tied to zero.
//
// Ports
//   clk24, rst        clock, synchronous active-high reset
//   wr_valid/addr/data write request from the converter
//   wr_frame_end      pulse on the last cycle of a converter frame
//   wr_ready          write FIFO not full
//   rd_req/rd_addr    display read request
//   rd_frame_start    pulse at display vsync
//   rd_data/rd_valid  read return (black until the first frame is shown)
//   frame_ready       a completed frame is on display
//   wr_overflow       sticky: a write was dropped on a full FIFO
//   mem_*             registered memory port, mem_addr = {bank, addr}
//   wr_drop_cnt       saturating dropped-write count
module frame_bank_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 48,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_LAT    = 1
) (
  input  logic              clk24,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_end,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_frame_start,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              frame_ready,
  output logic              wr_overflow,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       wr_drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_SYNC, ST_WRITE, ST_PEND} state_t;

  state_t state_q, state_d;

  logic              wr_bank_q;
  logic              rd_bank_q;
  logic              frame_ready_q;
  logic              overflow_q;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W:0]   mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;

  // Bit i is set i+1 cycles after a rd_req; the top bit lines up with mem_dout.
  logic [MEM_LAT:0]  rd_vld_sr_q;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push_try;
  logic push;
  logic drop;
  logic swap;

  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Reads own the port; the FIFO only drains in slots with no read.
  assign pop      = !rd_req && !fifo_empty;
  assign push_try = (state_q == ST_WRITE) && wr_valid;
  // A full FIFO still accepts a write when an entry leaves in the same cycle.
  assign push     = push_try && (!fifo_full || pop);
  assign drop     = push_try && fifo_full && !pop;
  // Only swap once every word of the finished frame has reached memory.
  assign swap     = (state_q == ST_PEND) && rd_frame_start && fifo_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:  if (wr_frame_end) state_d = ST_WRITE;
      ST_WRITE: if (wr_frame_end) state_d = ST_PEND;
      ST_PEND:  if (swap)         state_d = ST_SYNC;
      default:                    state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk24) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      frame_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
    end else begin
      state_q <= state_d;

      if (swap) begin
        rd_bank_q     <= wr_bank_q;
        wr_bank_q     <= ~wr_bank_q;
        frame_ready_q <= 1'b1;
      end

      if (drop) overflow_q <= 1'b1;

      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      // Idle slots leave address and data where they were.
      if (rd_req) begin
        mem_en_q   <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= {rd_bank_q, rd_addr};
      end else if (pop) begin
        mem_en_q   <= 1'b1;
        mem_we_q   <= 1'b1;
        mem_addr_q <= {wr_bank_q, fifo_addr_q[rd_ptr_q]};
        mem_din_q  <= fifo_data_q[rd_ptr_q];
      end else begin
        mem_en_q <= 1'b0;
        mem_we_q <= 1'b0;
      end
    end
  end

  // FIFO storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk24) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk24) begin
    if (rst) rd_vld_sr_q[0] <= 1'b0;
    else     rd_vld_sr_q[0] <= rd_req;
  end

  generate
    for (genvar gi = 1; gi <= MEM_LAT; gi++) begin : g_rd_vld
      always_ff @(posedge clk24) begin
        if (rst) rd_vld_sr_q[gi] <= 1'b0;
        else     rd_vld_sr_q[gi] <= rd_vld_sr_q[gi-1];
      end
    end
  endgenerate

`ifdef FRAME_BANK_STATS_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk24) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign wr_drop_cnt = drop_cnt_q;
`else
  assign wr_drop_cnt = '0;
`endif

  assign wr_ready    = ~fifo_full;
  assign rd_valid    = rd_vld_sr_q[MEM_LAT];
  // Until a finished frame is shown the bank holds garbage: return black.
  assign rd_data     = (rd_valid && frame_ready_q) ? mem_dout : '0;
  assign frame_ready = frame_ready_q;
  assign wr_overflow = overflow_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;

endmodule

// File: tb/tb_frame_bank_arbiter.sv
`timescale 1ns/1ps
module tb_frame_bank_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 48;

  logic              clk24 = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_end;
  logic              wr_ready;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_frame_start;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_ready;
  logic              wr_overflow;
  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout = '0;
  logic [15:0]       wr_drop_cnt;

  always #5 clk24 = ~clk24;

  frame_bank_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .MEM_LAT(1)
  ) dut (
    .clk24(clk24), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_end(wr_frame_end), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_frame_start(rd_frame_start),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_ready(frame_ready),
    .wr_overflow(wr_overflow),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_en(mem_en), .mem_we(mem_we),
    .mem_dout(mem_dout), .wr_drop_cnt(wr_drop_cnt)
  );

  // Memory model, one-cycle read latency. Unwritten words read back as
  // {28'hDEADBEE, address}.
  logic [DATA_W-1:0] mem_model [2048];
  bit                mem_written [2048];

  always @(posedge clk24) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) begin
        mem_model[{mem_addr[ADDR_W], mem_addr[9:0]}]   <= mem_din;
        mem_written[{mem_addr[ADDR_W], mem_addr[9:0]}] <= 1'b1;
      end else if (mem_written[{mem_addr[ADDR_W], mem_addr[9:0]}]) begin
        mem_dout <= mem_model[{mem_addr[ADDR_W], mem_addr[9:0]}];
      end else begin
        mem_dout <= {28'hDEADBEE, mem_addr};
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W:0]   exp_rd_addr_q [$];
  logic [DATA_W-1:0] exp_rd_data_q [$];
  logic [ADDR_W:0]   exp_wr_addr_q [$];
  logic [DATA_W-1:0] exp_wr_data_q [$];

  logic exp_rd_bank;
  logic exp_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected response whenever the DUT presents one.
  always @(negedge clk24) begin
    logic [ADDR_W:0]   ea;
    logic [DATA_W-1:0] ed;
    if (mem_en === 1'b1 && mem_we === 1'b0) begin
      if (exp_rd_addr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL mem_rd_unexpected: got addr %0h expected no access @%0t", mem_addr, $time);
      end else begin
        ea = exp_rd_addr_q.pop_front();
        $display("mem rd addr=%0h exp=%0h", mem_addr, ea);
        chk("mem_rd_addr", 64'(mem_addr), 64'(ea));
      end
    end
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      if (exp_wr_addr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL mem_wr_unexpected: got addr %0h expected no access @%0t", mem_addr, $time);
      end else begin
        ea = exp_wr_addr_q.pop_front();
        ed = exp_wr_data_q.pop_front();
        $display("mem wr addr=%0h din=%0h exp=%0h/%0h", mem_addr, mem_din, ea, ed);
        chk("mem_wr_addr", 64'(mem_addr), 64'(ea));
        chk("mem_wr_data", 64'(mem_din), 64'(ed));
      end
    end
    if (rd_valid === 1'b1) begin
      if (exp_rd_data_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_valid_unexpected: got data %0h expected no return @%0t", rd_data, $time);
      end else begin
        ed = exp_rd_data_q.pop_front();
        $display("rd ret data=%0h exp=%0h", rd_data, ed);
        chk("rd_data", 64'(rd_data), 64'(ed));
      end
    end
  end

  task automatic push_wr(input logic [ADDR_W:0] a, input logic [DATA_W-1:0] d);
    exp_wr_addr_q.push_back(a);
    exp_wr_data_q.push_back(d);
  endtask

  // One cycle of stimulus; inputs are sampled at the next posedge and the
  // task returns at the following negedge.
  task automatic drive(input logic rd, input logic [ADDR_W-1:0] ra, input logic [DATA_W-1:0] rexp,
                       input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic fe, input logic fs);
    rd_req = rd; rd_addr = ra;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    wr_frame_end = fe; rd_frame_start = fs;
    if (rd) begin
      exp_rd_addr_q.push_back({exp_rd_bank, ra});
      exp_rd_data_q.push_back(exp_ready ? rexp : '0);
    end
    @(negedge clk24);
    rd_req = 1'b0; wr_valid = 1'b0; wr_frame_end = 1'b0; rd_frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr_ready"},    64'(wr_ready),    64'd1);
    chk({tag, "_frame_ready"}, 64'(frame_ready), 64'd0);
    chk({tag, "_wr_overflow"}, 64'(wr_overflow), 64'd0);
    chk({tag, "_rd_valid"},    64'(rd_valid),    64'd0);
    chk({tag, "_rd_data"},     64'(rd_data),     64'd0);
    chk({tag, "_mem_en"},      64'(mem_en),      64'd0);
    chk({tag, "_mem_we"},      64'(mem_we),      64'd0);
    chk({tag, "_mem_addr"},    64'(mem_addr),    64'd0);
    chk({tag, "_drop_cnt"},    64'(wr_drop_cnt), 64'd0);
  endtask

  logic [15:0] exp_drop;

  initial begin
`ifdef FRAME_BANK_STATS_EN
    exp_drop = 16'd1;
`else
    exp_drop = 16'd0;
`endif
    rst = 1'b1;
    rd_req = 1'b0; rd_addr = '0; rd_frame_start = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_frame_end = 1'b0;
    exp_rd_bank = 1'b1;
    exp_ready   = 1'b0;

    idle(3);
    chk_reset_state("rst");
    chk("rst_mem_din", 64'(mem_din), 64'd0);
    rst = 1'b0;

    // SYNC: writes are ignored entirely.
    drive(1'b0, '0, '0, 1'b1, 19'd5, 48'h555, 1'b0, 1'b0);
    idle(3);
    chk("sync_mem_en",   64'(mem_en),      64'd0);
    chk("sync_overflow", 64'(wr_overflow), 64'd0);
    chk("sync_wr_ready", 64'(wr_ready),    64'd1);

    // Enter WRITE; any write wrongly captured in SYNC would drain here.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(2);

    // Single write reaches the memory port two cycles after the push.
    push_wr({1'b0, 19'd7}, 48'hABC);
    drive(1'b0, '0, '0, 1'b1, 19'd7, 48'hABC, 1'b0, 1'b0);
    chk("wr1_early_mem_en", 64'(mem_en), 64'd0);
    idle(1);
    chk("wr1_mem_en",   64'(mem_en),   64'd1);
    chk("wr1_mem_we",   64'(mem_we),   64'd1);
    chk("wr1_mem_addr", 64'(mem_addr), 64'h00007);
    chk("wr1_mem_din",  64'(mem_din),  64'hABC);
    idle(2);

    // Reads held high starve the FIFO: four fit, the fifth is dropped.
    for (int i = 0; i < 4; i++) push_wr({1'b0, 19'h20 + 19'(i)}, 48'h111 * 48'(i + 1));
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 19'h10, '0, 1'b1, 19'h20 + 19'(i), 48'h111 * 48'(i + 1), 1'b0, 1'b0);
      if (i == 2) chk("fill3_wr_ready", 64'(wr_ready), 64'd1);
      if (i == 3) chk("fill4_wr_ready", 64'(wr_ready), 64'd0);
    end
    chk("fill_overflow", 64'(wr_overflow), 64'd1);
    chk("fill_drop_cnt", 64'(wr_drop_cnt), 64'(exp_drop));

    // Frame end, let the FIFO drain, then swap at the display frame start.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(4);
    chk("drain_wr_ready", 64'(wr_ready), 64'd1);
    chk("pre_swap_frame_ready", 64'(frame_ready), 64'd0);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    exp_rd_bank = 1'b0;
    exp_ready   = 1'b1;
    chk("swap_frame_ready", 64'(frame_ready), 64'd1);

    // Reads now come from bank 0, two cycles after the request.
    drive(1'b1, 19'd3, 48'hDEADBEE00003, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("rd3_mem_addr", 64'(mem_addr), 64'h00003);
    chk("rd3_valid_early", 64'(rd_valid), 64'd0);
    idle(1);
    chk("rd3_valid", 64'(rd_valid), 64'd1);
    chk("rd3_data",  64'(rd_data),  64'hDEADBEE00003);
    drive(1'b1, 19'd7,  48'hABC, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 19'h20, 48'h111, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("b2b_valid1", 64'(rd_valid), 64'd1);
    idle(1);
    chk("b2b_valid2", 64'(rd_valid), 64'd1);
    idle(2);

    // PEND with two entries queued behind continuous reads: no swap.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    push_wr({1'b1, 19'h30}, 48'hAAA);
    push_wr({1'b1, 19'h31}, 48'hBBB);
    drive(1'b1, 19'h40, 48'hDEADBEE00040, 1'b1, 19'h30, 48'hAAA, 1'b0, 1'b0);
    drive(1'b1, 19'h40, 48'hDEADBEE00040, 1'b1, 19'h31, 48'hBBB, 1'b1, 1'b0);
    drive(1'b1, 19'h41, 48'hDEADBEE00041, 1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b1, 19'h41, 48'hDEADBEE00041, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(3);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    exp_rd_bank = 1'b1;
    drive(1'b1, 19'h30, 48'hAAA, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 19'h31, 48'hBBB, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(3);
    chk("pend_frame_ready", 64'(frame_ready), 64'd1);

    // Reset, then a read before any swap returns black.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    exp_rd_bank = 1'b1;
    exp_ready   = 1'b0;
    chk_reset_state("rst2");
    drive(1'b1, 19'd5, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(3);

    // Reset lands while a read is in flight: its return must never appear.
    drive(1'b1, 19'd6, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    void'(exp_rd_data_q.pop_back());
    rst = 1'b1;
    idle(1);
    chk_reset_state("midrd");
    rst = 1'b0;
    idle(3);

    chk("left_rd_addr", 64'(exp_rd_addr_q.size()), 64'd0);
    chk("left_rd_data", 64'(exp_rd_data_q.size()), 64'd0);
    chk("left_wr",      64'(exp_wr_addr_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
